// File: rtl/voice_allocator.sv
// voice_allocator: polyphonic voice dispatcher driving a row of notebank voices.
// Accepts key press/release events, two clocks per event (IDLE -> DECIDE), and
// issues registered note_on/note_off pulses plus a per-voice period.
// Optional build macro VOICE_STEAL_EN: when defined, a press with no free voice
// steals the oldest voice; otherwise such a press is dropped.

// One notebank voice slot: lifecycle state, owned key code and period.
module voice_slot (
    input  logic        clk_slow,
    input  logic        rst,
    input  logic        load,
    input  logic        rel,
    input  logic        done,
    input  logic [6:0]  code_in,
    input  logic [22:0] period_in,
    output logic        busy,
    output logic        active,
    output logic [6:0]  code,
    output logic [22:0] period
);
    typedef enum logic [1:0] {V_FREE, V_ACTIVE, V_RELEASING} vstate_t;
    vstate_t state;

    // load (allocate/retrigger/steal) outranks release and done, so a
    // retrigger that lands on the same edge as done keeps the voice ACTIVE.
    always_ff @(posedge clk_slow) begin
        if (rst) begin
            state  <= V_FREE;
            code   <= '0;
            period <= '0;
        end else if (load) begin
            state  <= V_ACTIVE;
            code   <= code_in;
            period <= period_in;
        end else if (rel && state == V_ACTIVE) begin
            state <= V_RELEASING;
        end else if (done && state == V_RELEASING) begin
            state <= V_FREE;
        end
    end

    assign busy   = (state != V_FREE);
    assign active = (state == V_ACTIVE);
endmodule

module voice_allocator #(
    parameter int NUM_VOICES = 4,
    parameter int AGE_W      = 4
) (
    input  logic                    clk_slow,
    input  logic                    rst,
    input  logic                    key_valid,
    output logic                    key_ready,
    input  logic                    key_down,
    input  logic [6:0]              key_code,
    input  logic [22:0]             key_period,
    input  logic                    panic,
    input  logic [NUM_VOICES-1:0]   done,
    output logic [NUM_VOICES-1:0]   note_on,
    output logic [NUM_VOICES-1:0]   note_off,
    output logic [23*NUM_VOICES-1:0] period_bus,
    output logic [NUM_VOICES-1:0]   voice_busy,
    output logic                    key_dropped
);
    typedef enum logic {IDLE, DECIDE} state_t;
    state_t state, state_n;

    logic        ev_down;
    logic [6:0]  ev_code;
    logic [22:0] ev_period;

    logic [NUM_VOICES-1:0]            active, match, rel_hit, load, rel;
    logic [NUM_VOICES-1:0][6:0]       code;
    logic [NUM_VOICES-1:0][AGE_W-1:0] age;
    logic                             drop_n;

    // Lowest-index set bit of a voice mask, one-hot.
    function automatic logic [NUM_VOICES-1:0] first_set(input logic [NUM_VOICES-1:0] x);
        first_set = '0;
        for (int i = NUM_VOICES - 1; i >= 0; i--)
            if (x[i]) begin
                first_set    = '0;
                first_set[i] = 1'b1;
            end
    endfunction

    for (genvar v = 0; v < NUM_VOICES; v++) begin : g_voice
        voice_slot u_slot (
            .clk_slow  (clk_slow),
            .rst       (rst),
            .load      (load[v]),
            .rel       (rel[v]),
            .done      (done[v]),
            .code_in   (ev_code),
            .period_in (ev_period),
            .busy      (voice_busy[v]),
            .active    (active[v]),
            .code      (code[v]),
            .period    (period_bus[v*23 +: 23])
        );
        // A press retriggers any sounding voice with its key; a release only
        // hits a voice that is still ACTIVE.
        assign match[v]   = voice_busy[v] && (code[v] == ev_code);
        assign rel_hit[v] = active[v] && (code[v] == ev_code);
    end

`ifdef VOICE_STEAL_EN
    logic [NUM_VOICES-1:0] victim;
    logic [AGE_W-1:0]      best;

    // Oldest busy voice; strict '>' keeps the lowest index on ties.
    always_comb begin
        victim = '0;
        best   = '0;
        for (int v = 0; v < NUM_VOICES; v++)
            if (voice_busy[v] && (victim == '0 || age[v] > best)) begin
                victim    = '0;
                victim[v] = 1'b1;
                best      = age[v];
            end
    end
`endif

    assign key_ready = (state == IDLE);

    // Next state and event resolution; panic overrides a pending event.
    always_comb begin
        state_n = state;
        load    = '0;
        rel     = '0;
        drop_n  = 1'b0;
        case (state)
            IDLE:    if (key_valid && !panic) state_n = DECIDE;
            DECIDE:  state_n = IDLE;
            default: state_n = IDLE;
        endcase
        if (panic) begin
            rel    = active;
            drop_n = (state == DECIDE) && ev_down;
        end else if (state == DECIDE) begin
            if (ev_down) begin
                if (|match)
                    load = first_set(match);
                else if (~&voice_busy)
                    load = first_set(~voice_busy);
                else begin
`ifdef VOICE_STEAL_EN
                    load = victim;
`else
                    drop_n = 1'b1;
`endif
                end
            end else begin
                rel = first_set(rel_hit);
            end
        end
    end

    // FSM state, event latch and registered pulse outputs.
    always_ff @(posedge clk_slow) begin
        if (rst) begin
            state       <= IDLE;
            ev_down     <= 1'b0;
            ev_code     <= '0;
            ev_period   <= '0;
            note_on     <= '0;
            note_off    <= '0;
            key_dropped <= 1'b0;
        end else begin
            state       <= state_n;
            note_on     <= load;
            note_off    <= rel;
            key_dropped <= drop_n;
            if (state == IDLE && key_valid && !panic) begin
                ev_down   <= key_down;
                ev_code   <= key_code;
                ev_period <= key_period;
            end
        end
    end

    // Ages move only on a resolved press: target to 0, other busy voices +1 saturating.
    always_ff @(posedge clk_slow) begin
        if (rst) begin
            age <= '0;
        end else if (|load) begin
            for (int v = 0; v < NUM_VOICES; v++)
                if (load[v])
                    age[v] <= '0;
                else if (voice_busy[v] && age[v] != '1)
                    age[v] <= age[v] + AGE_W'(1);
        end
    end
endmodule

// File: tb/tb_voice_allocator.sv
// Directed bench for voice_allocator (NUM_VOICES=4), hand-computed expectations.
module tb_voice_allocator;
    localparam int NV = 4;

    logic           clk_slow = 1'b0;
    logic           rst = 1'b0;
    logic           key_valid = 1'b0;
    logic           key_ready;
    logic           key_down = 1'b0;
    logic [6:0]     key_code = '0;
    logic [22:0]    key_period = '0;
    logic           panic = 1'b0;
    logic [NV-1:0]  done = '0;
    logic [NV-1:0]  note_on, note_off, voice_busy;
    logic [23*NV-1:0] period_bus;
    logic           key_dropped;

    int n_chk = 0;
    int n_bad = 0;

    voice_allocator #(.NUM_VOICES(NV), .AGE_W(4)) dut (
        .clk_slow    (clk_slow),
        .rst         (rst),
        .key_valid   (key_valid),
        .key_ready   (key_ready),
        .key_down    (key_down),
        .key_code    (key_code),
        .key_period  (key_period),
        .panic       (panic),
        .done        (done),
        .note_on     (note_on),
        .note_off    (note_off),
        .period_bus  (period_bus),
        .voice_busy  (voice_busy),
        .key_dropped (key_dropped)
    );

    always #5 clk_slow = ~clk_slow;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] per(input int v);
        return {9'd0, period_bus[v*23 +: 23]};
    endfunction

    task automatic tick();
        @(posedge clk_slow);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Issue one event; pn/dn/rs are applied during the DECIDE cycle.
    // Returns #1 after the edge where the event's outputs appear.
    task automatic key_event(input logic down, input logic [6:0] code, input logic [22:0] p,
                             input logic pn, input logic [NV-1:0] dn, input logic rs);
        int n = 0;
        while (!key_ready && n < 20) begin
            tick();
            n++;
        end
        chk("ready_wait", {31'd0, key_ready}, 32'd1);
        key_valid = 1'b1; key_down = down; key_code = code; key_period = p;
        tick();
        key_valid = 1'b0; panic = pn; done = dn; rst = rs;
        tick();
        panic = 1'b0; done = '0; rst = 1'b0;
    endtask

    task automatic press(input logic [6:0] code, input logic [22:0] p);
        key_event(1'b1, code, p, 1'b0, '0, 1'b0);
    endtask

    task automatic release_key(input logic [6:0] code);
        key_event(1'b0, code, 23'd0, 1'b0, '0, 1'b0);
    endtask

    initial begin
        #1;
        do_reset();
        chk("rst_ready", {31'd0, key_ready}, 32'd1);
        chk("rst_busy", {28'd0, voice_busy}, 32'd0);
        chk("rst_on", {28'd0, note_on}, 32'd0);
        chk("rst_off", {28'd0, note_off}, 32'd0);
        chk("rst_drop", {31'd0, key_dropped}, 32'd0);
        chk("rst_per0", per(0), 32'd0);

        // First allocation
        press(7'd60, 23'd1000);
        chk("p60_on", {28'd0, note_on}, 32'h1);
        chk("p60_per", per(0), 32'd1000);
        chk("p60_busy", {28'd0, voice_busy}, 32'h1);
        tick();
        chk("p60_pulse1", {28'd0, note_on}, 32'h0);

        // Fill, then release the middle voice
        press(7'd62, 23'd2000);
        chk("p62_on", {28'd0, note_on}, 32'h2);
        press(7'd64, 23'd3000);
        chk("p64_on", {28'd0, note_on}, 32'h4);
        release_key(7'd62);
        chk("r62_off", {28'd0, note_off}, 32'h2);
        chk("r62_on", {28'd0, note_on}, 32'h0);
        chk("r62_busy", {28'd0, voice_busy}, 32'h7);
        tick();
        chk("r62_off_pulse", {28'd0, note_off}, 32'h0);
        chk("r62_hold", {28'd0, voice_busy}, 32'h7);
        chk("r62_per_kept", per(1), 32'd2000);
        done = 4'b0010;
        tick();
        done = '0;
        chk("done1_busy", {28'd0, voice_busy}, 32'h5);

        // Release with no matching voice: silent
        release_key(7'd99);
        chk("r99_off", {28'd0, note_off}, 32'h0);
        chk("r99_drop", {31'd0, key_dropped}, 32'd0);

        // Retrigger of voice 0
        press(7'd60, 23'd900);
        chk("retrig_on", {28'd0, note_on}, 32'h1);
        chk("retrig_per", per(0), 32'd900);
        chk("retrig_busy", {28'd0, voice_busy}, 32'h5);

        // All voices busy, then one more press
        do_reset();
        press(7'd60, 23'd1000);
        press(7'd62, 23'd2000);
        press(7'd64, 23'd3000);
        press(7'd65, 23'd4000);
        chk("full_busy", {28'd0, voice_busy}, 32'hF);
        press(7'd67, 23'd5000);
`ifdef VOICE_STEAL_EN
        chk("steal_on", {28'd0, note_on}, 32'h1);
        chk("steal_per", per(0), 32'd5000);
        chk("steal_drop", {31'd0, key_dropped}, 32'd0);
`else
        chk("nosteal_drop", {31'd0, key_dropped}, 32'd1);
        chk("nosteal_on", {28'd0, note_on}, 32'h0);
        chk("nosteal_per", per(0), 32'd1000);
        tick();
        chk("nosteal_drop_pulse", {31'd0, key_dropped}, 32'd0);
`endif
        chk("full_busy2", {28'd0, voice_busy}, 32'hF);

        // Panic releases every active voice
        panic = 1'b1;
        tick();
        panic = 1'b0;
        chk("panic_off", {28'd0, note_off}, 32'hF);
        chk("panic_on", {28'd0, note_on}, 32'h0);
        chk("panic_busy", {28'd0, voice_busy}, 32'hF);
        tick();
        chk("panic_off_pulse", {28'd0, note_off}, 32'h0);
        done = 4'b1111;
        tick();
        done = '0;
        chk("panic_done_busy", {28'd0, voice_busy}, 32'h0);

        // Panic arriving during DECIDE of a press
        press(7'd70, 23'd700);
        chk("p70_on", {28'd0, note_on}, 32'h1);
        key_event(1'b1, 7'd72, 23'd720, 1'b1, '0, 1'b0);
        chk("pd_off", {28'd0, note_off}, 32'h1);
        chk("pd_on", {28'd0, note_on}, 32'h0);
        chk("pd_drop", {31'd0, key_dropped}, 32'd1);
        chk("pd_busy", {28'd0, voice_busy}, 32'h1);
        done = 4'b0001;
        tick();
        done = '0;
        chk("pd_free", {28'd0, voice_busy}, 32'h0);

        // Retrigger of a releasing voice coinciding with done
        press(7'd80, 23'd800);
        release_key(7'd80);
        chk("r80_off", {28'd0, note_off}, 32'h1);
        key_event(1'b1, 7'd80, 23'd1234, 1'b0, 4'b0001, 1'b0);
        chk("rd_on", {28'd0, note_on}, 32'h1);
        chk("rd_busy", {28'd0, voice_busy}, 32'h1);
        chk("rd_per", per(0), 32'd1234);
        done = 4'b0001;
        tick();
        done = '0;
        chk("active_ignores_done", {28'd0, voice_busy}, 32'h1);

        // Reset during DECIDE of a press
        key_event(1'b1, 7'd90, 23'd900, 1'b0, '0, 1'b1);
        chk("rd_rst_on", {28'd0, note_on}, 32'h0);
        chk("rd_rst_ready", {31'd0, key_ready}, 32'd1);
        chk("rd_rst_busy", {28'd0, voice_busy}, 32'h0);
        chk("rd_rst_per", per(0), 32'd0);

        $display("%0d/%0d checks passed", n_chk - n_bad, n_chk);
        $finish;
    end
endmodule
